router_ctrl: RTL
================

# router_ctrl

Control block of the 1x3 router: sequences header decode, payload load, FIFO-full stall and parity check for each incoming packet, and steers write strobes to one of three output FIFOs. It also drives per-port valid flags and a per-port soft-reset timeout for readers that stall. It sits between the source-side input pins (`pkt_valid`, `data_in`, `busy`) and the router's register block and three output FIFOs.

## Interface
Parameters:
- `TIMEOUT`, 30: consecutive stalled cycles before a port's soft reset fires. Legal range 2–31.

Ports:
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, synchronous and active-low.
- `pkt_valid`  in  1: source asserts for header plus payload. Deasserts on the parity byte.
- `data_in`  in  2: bits [1:0] of the input byte; the destination address when a header is presented.
- `fifo_full`  in  3: per-FIFO full flag.
- `fifo_empty`  in  3: per-FIFO empty flag.
- `read_enb`  in  3: per-port read enable from the destination readers.
- `parity_done`  in  1: register block has captured the parity byte.
- `low_pkt_valid`  in  1: register block saw `pkt_valid` fall while stalled.
- `busy`  out  1: source must hold `data_in`.
- `write_enb`  out  3: one-hot FIFO write strobe.
- `vld_out`  out  3: per-port data available.
- `soft_reset`  out  3: per-port one-cycle flush pulse.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`  out  1 each: state decodes for the register block.

## Operation
- FSM states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- `addr` register (2 bit) latches `data_in` when the FSM is in DECODE_ADDRESS and `pkt_valid`=1. `addr`=3 is illegal.
- Transitions:
  - DECODE_ADDRESS:
    - `pkt_valid` and `addr`≠3 and `fifo_empty[addr]` → LOAD_FIRST_DATA.
    - `pkt_valid` and `addr`≠3 and not empty → WAIT_TILL_EMPTY.
    - Otherwise stay; a header with `addr`=3 is ignored.
  - WAIT_TILL_EMPTY: `fifo_empty[addr]` → LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA: `fifo_full[addr]` → FIFO_FULL_STATE. Else `!pkt_valid` → LOAD_PARITY. Else stay. Full has priority.
  - FIFO_FULL_STATE: stay while `fifo_full[addr]`, else → LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL: `parity_done` → DECODE_ADDRESS. Else `low_pkt_valid` → LOAD_PARITY. Else → LOAD_DATA.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full[addr]` → FIFO_FULL_STATE, else → DECODE_ADDRESS.
  - Any state: `soft_reset[addr]`=1 → DECODE_ADDRESS next cycle. This has highest priority after `resetn`.
- Moore outputs:
  - `busy`=1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY. `busy`=0 in DECODE_ADDRESS and LOAD_DATA.
  - `write_enb[addr]`=1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY. All other `write_enb` bits are 0.
  - `detect_add`, `lfd_state`, `ld_state`, `laf_state` and `full_state` are each 1 in their matching state.
  - `rst_int_reg`=1 in CHECK_PARITY_ERROR.
- `vld_out[i]` = `!fifo_empty[i]`, combinational.
- Soft-reset timeout, one 5-bit counter per port:
  - Increments while `vld_out[i]` and `!read_enb[i]`.
  - Clears on `read_enb[i]`=1 or `vld_out[i]`=0.
  - On the edge where it would reach `TIMEOUT`, it clears and `soft_reset[i]` goes high for exactly one cycle.

## Timing
- State, `addr`, counters and `soft_reset` are registered. FSM-derived outputs decode from the state register and are valid in the same cycle.
- Header accepted at edge N. `busy`=1 and `lfd_state`=1 from N to N+1. `ld_state`=1 from N+1 on.
- `fifo_full` sampled in LOAD_DATA at edge N gives `busy`=1 in the next cycle. The byte presented at edge N is held by the register block, not by this block.
- Reset values while `resetn`=0 at an edge:
  - State is DECODE_ADDRESS, `addr`=0 and all counters are 0.
  - `busy`=0, `write_enb`=0, `soft_reset`=0, `detect_add`=1 and all other decodes are 0.
  - `vld_out` follows `fifo_empty`.
- `resetn` low mid-packet: return to DECODE_ADDRESS in the next cycle. The partial packet is abandoned.
- `soft_reset` on a port other than `addr` does not affect the FSM. Only that port's counter clears.
- Counters never wrap. A simultaneous `read_enb` and terminal count clears the counter with no pulse.

## Configuration
- `ROUTER_CTRL_SOFT_RESET_EN`:
  - Defined: timeout counters, the `soft_reset` pulse and the soft-reset FSM abort path exist as described.
  - Undefined: counters are not built, `soft_reset` is tied to 3'b000 and the FSM ignores the abort path.

## Test plan
- Reset, then header 0x05 (`addr`=1) with `fifo_empty`=3'b111, 4 payload bytes, then parity:
  - States run DECODE→LFD→LD×4→LP→CPE→DECODE.
  - `write_enb`=3'b010 for 6 cycles.
  - `busy` high in LFD, LP and CPE only.
- Header `addr`=2 with `fifo_empty[2]`=0, released after 5 cycles: FSM stays in WAIT_TILL_EMPTY with `busy`=1 for 5 cycles, then enters LFD.
- `fifo_full[0]` raised mid-LOAD_DATA for 3 cycles, then dropped:
  - FSM is in FIFO_FULL for 3 cycles, then LAF, then LD.
  - `write_enb`=0 while in the full state.
  - The same sequence with `low_pkt_valid`=1 in LAF goes to LP.
- `fifo_empty[2]`=0 with `read_enb[2]`=0 held for 30 cycles:
  - `soft_reset[2]` pulses for 1 cycle.
  - A `read_enb` pulse at cycle 29 resets the count and gives no pulse.
- Header `addr`=3: `write_enb` stays 0, `busy` stays 0 and the FSM stays in DECODE_ADDRESS.
- `resetn`=0 for 1 cycle during LOAD_DATA: next cycle all outputs are at reset values. The macro-off build shows `soft_reset`=0 under the stall stimulus.

Source files
------------

// File: rtl/router_ctrl.sv
`timescale 1ns/1ps
// router_ctrl: packet sequencing FSM for the 1x3 router.
// Decodes the header address, steers one-hot FIFO write strobes, stalls the
// source on a full FIFO, and hands state decodes to the register block.
// Optional feature macro: ROUTER_CTRL_SOFT_RESET_EN. When defined, per-port
// stall timeout counters raise a one-cycle soft_reset pulse and that pulse
// on the active port aborts the packet. When undefined, soft_reset is tied
// low and no counters are built.
module router_ctrl #(
   parameter int TIMEOUT = 30
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic [2:0] fifo_full,
   input  logic [2:0] fifo_empty,
   input  logic [2:0] read_enb,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       busy,
   output logic [2:0] write_enb,
   output logic [2:0] vld_out,
   output logic [2:0] soft_reset,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] addr_reg;
   logic [1:0] addr_next;

   // Flag vectors padded to four entries so the illegal address 3 indexes a
   // constant zero instead of running off the end of a 3-bit vector.
   logic [3:0] full_ext;
   logic [3:0] empty_ext;
   logic [3:0] srst_ext;
   logic       abort;

   assign full_ext  = {1'b0, fifo_full};
   assign empty_ext = {1'b0, fifo_empty};
   assign srst_ext  = {1'b0, soft_reset};

   // Reader-side valid flags are a straight view of the FIFO empty flags.
   assign vld_out = ~fifo_empty;

`ifdef ROUTER_CTRL_SOFT_RESET_EN
   // Only a soft reset on the port currently being written aborts the packet.
   assign abort = srst_ext[addr_reg];

   localparam logic [4:0] TERM_COUNT = 5'(TIMEOUT - 1);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_timeout
         logic [4:0] cnt_reg;
         logic       pulse_reg;

         // Count consecutive stalled cycles; fire a one-cycle pulse instead
         // of reaching TIMEOUT, and restart from zero after it.
         always_ff @(posedge clock) begin
            if (!resetn) begin
               cnt_reg   <= 5'd0;
               pulse_reg <= 1'b0;
            end else if (vld_out[gi] && !read_enb[gi]) begin
               if (cnt_reg == TERM_COUNT) begin
                  cnt_reg   <= 5'd0;
                  pulse_reg <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + 5'd1;
                  pulse_reg <= 1'b0;
               end
            end else begin
               cnt_reg   <= 5'd0;
               pulse_reg <= 1'b0;
            end
         end

         assign soft_reset[gi] = pulse_reg;
      end
   endgenerate
`else
   // Without the timeout feature, the read enables have no consumer here.
   logic unused_read_enb;
   assign unused_read_enb = ^read_enb;
   assign abort           = 1'b0;
   assign soft_reset      = 3'b000;
`endif

   // State and destination address registers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg <= DECODE_ADDRESS;
         addr_reg  <= 2'd0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
      end
   end

   // Next-state logic. In DECODE_ADDRESS the address register is still being
   // loaded, so the header decision looks at data_in directly.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      if (state_reg == DECODE_ADDRESS && pkt_valid) begin
         addr_next = data_in;
      end
      if (abort) begin
         state_next = DECODE_ADDRESS;
      end else begin
         case (state_reg)
            DECODE_ADDRESS: begin
               if (pkt_valid && data_in != 2'd3) begin
                  if (empty_ext[data_in]) begin
                     state_next = LOAD_FIRST_DATA;
                  end else begin
                     state_next = WAIT_TILL_EMPTY;
                  end
               end
            end
            WAIT_TILL_EMPTY: begin
               if (empty_ext[addr_reg]) begin
                  state_next = LOAD_FIRST_DATA;
               end
            end
            LOAD_FIRST_DATA: begin
               state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
               if (full_ext[addr_reg]) begin
                  state_next = FIFO_FULL_STATE;
               end else if (!pkt_valid) begin
                  state_next = LOAD_PARITY;
               end
            end
            FIFO_FULL_STATE: begin
               if (!full_ext[addr_reg]) begin
                  state_next = LOAD_AFTER_FULL;
               end
            end
            LOAD_AFTER_FULL: begin
               if (parity_done) begin
                  state_next = DECODE_ADDRESS;
               end else if (low_pkt_valid) begin
                  state_next = LOAD_PARITY;
               end else begin
                  state_next = LOAD_DATA;
               end
            end
            LOAD_PARITY: begin
               state_next = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
               if (full_ext[addr_reg]) begin
                  state_next = FIFO_FULL_STATE;
               end else begin
                  state_next = DECODE_ADDRESS;
               end
            end
            default: begin
               state_next = DECODE_ADDRESS;
            end
         endcase
      end
   end

   // Moore outputs decoded from the state register only.
   always_comb begin
      busy        = 1'b0;
      write_enb   = 3'b000;
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      rst_int_reg = 1'b0;
      case (state_reg)
         DECODE_ADDRESS: begin
            detect_add = 1'b1;
         end
         LOAD_FIRST_DATA: begin
            busy      = 1'b1;
            lfd_state = 1'b1;
            write_enb = 3'b001 << addr_reg;
         end
         LOAD_DATA: begin
            ld_state  = 1'b1;
            write_enb = 3'b001 << addr_reg;
         end
         FIFO_FULL_STATE: begin
            busy       = 1'b1;
            full_state = 1'b1;
         end
         LOAD_AFTER_FULL: begin
            busy      = 1'b1;
            laf_state = 1'b1;
            write_enb = 3'b001 << addr_reg;
         end
         LOAD_PARITY: begin
            busy      = 1'b1;
            write_enb = 3'b001 << addr_reg;
         end
         CHECK_PARITY_ERROR: begin
            busy        = 1'b1;
            rst_int_reg = 1'b1;
         end
         WAIT_TILL_EMPTY: begin
            busy = 1'b1;
         end
         default: begin
            detect_add = 1'b1;
         end
      endcase
   end

endmodule
